// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default sizes and the parity helper
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Even parity when odd==0, odd parity when odd==1.
  function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes between the CPU-side handshake and the serialiser.
// Read data is the entry at the read pointer, so a pop consumes it on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // Full is judged on pre-edge state, so a simultaneous pop never lets a push into a full FIFO.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes from a valid/ready source and serialises them as
// start, 8 data bits LSB first, optional parity and 1 or 2 stop bits on the shared baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clk_tx,
  input  logic [UART_DATA_W-1:0] i_tx_data,
  input  logic                   i_tx_valid,
  output logic                   o_tx_ready,
  output logic                   o_txd,
  output logic                   o_tx_busy,
  output logic                   TxDone
);

  localparam int                TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_W - 1);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);
  localparam logic              USE_PAR   = (PARITY_EN != 0);
  localparam logic              TWO_STOP  = (STOP_BITS == 2);

  uart_state_t            state_reg, state_next;
  logic [TICK_W-1:0]      tick_cnt_reg, tick_cnt_next;
  logic [2:0]             bit_cnt_reg, bit_cnt_next;
  logic [UART_DATA_W-1:0] shift_reg, shift_next;
  logic                   parity_reg, parity_next;
  logic                   stop_cnt_reg, stop_cnt_next;
  logic                   txd_reg, txd_next;

  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_data;
  logic [CNT_W-1:0]       fifo_count;
  logic                   bit_end;
  logic                   load_frame;
  logic                   tx_done;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (i_tx_valid && o_tx_ready),
    .push_data (i_tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bit_end = i_clk_tx && (tick_cnt_reg == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      stop_cnt_reg <= 1'b0;
      txd_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      stop_cnt_reg <= stop_cnt_next;
      txd_reg      <= txd_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    stop_cnt_next = stop_cnt_reg;
    fifo_pop      = 1'b0;
    load_frame    = 1'b0;
    tx_done       = 1'b0;

    if (state_reg != ST_IDLE && i_clk_tx) begin
      tick_cnt_next = bit_end ? '0 : tick_cnt_reg + 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        load_frame = !fifo_empty;
      end
      ST_START: begin
        if (bit_end) begin
          state_next   = ST_DATA;
          bit_cnt_next = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_next   = shift_reg >> 1;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next    = USE_PAR ? ST_PARITY : ST_STOP;
            stop_cnt_next = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_next    = ST_STOP;
          stop_cnt_next = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!TWO_STOP || stop_cnt_reg) begin
            tx_done    = 1'b1;
            state_next = ST_IDLE;
            load_frame = !fifo_empty;
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A new frame may start from IDLE or straight out of the last stop bit.
    if (load_frame) begin
      fifo_pop      = 1'b1;
      shift_next    = fifo_data;
      parity_next   = uart_parity(fifo_data, PAR_ODD);
      tick_cnt_next = '0;
      bit_cnt_next  = '0;
      stop_cnt_next = 1'b0;
      state_next    = ST_START;
    end
  end

  always_comb begin
    txd_next = 1'b1;
    case (state_reg)
      ST_START:  txd_next = 1'b0;
      ST_DATA:   txd_next = shift_reg[0];
      ST_PARITY: txd_next = parity_reg;
      default:   txd_next = 1'b1;
    endcase
  end

  assign o_txd      = txd_reg;
  assign o_tx_ready = !fifo_full;
  assign o_tx_busy  = (state_reg != ST_IDLE) || (fifo_count != '0);
  assign TxDone     = tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (8N1, 8O2, 8E2) checked bit-window by bit-window
// against frames built from the pushed bytes.
module tb_uart_tx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_clk_tx = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] valid_v = 3'b000;
  logic [2:0] ready_v, txd_v, busy_v, done_v;

  int   n_checks = 0;
  int   n_errors = 0;
  int   tick_period = 4;
  int   phase = 0;
  logic tick_en = 1'b0;

  int par_en  [3] = '{0, 1, 1};
  int par_odd [3] = '{0, 1, 0};
  int stops   [3] = '{1, 2, 2};

  always #5 clk = ~clk;

  uart_tx #(.OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .i_clk_tx(i_clk_tx), .i_tx_data(tx_data), .i_tx_valid(valid_v[0]),
    .o_tx_ready(ready_v[0]), .o_txd(txd_v[0]), .o_tx_busy(busy_v[0]), .TxDone(done_v[0]));

  uart_tx #(.OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .i_clk_tx(i_clk_tx), .i_tx_data(tx_data), .i_tx_valid(valid_v[1]),
    .o_tx_ready(ready_v[1]), .o_txd(txd_v[1]), .o_tx_busy(busy_v[1]), .TxDone(done_v[1]));

  uart_tx #(.OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .i_clk_tx(i_clk_tx), .i_tx_data(tx_data), .i_tx_valid(valid_v[2]),
    .o_tx_ready(ready_v[2]), .o_txd(txd_v[2]), .o_tx_busy(busy_v[2]), .TxDone(done_v[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive the baud tick for the coming edge, then move to the next falling edge.
  task automatic cyc();
    i_clk_tx = tick_en && (phase == 0);
    phase = (phase + 1) % tick_period;
    @(negedge clk);
  endtask

  // align places the first baud tick on the edge that pops the byte, giving a full-length start bit.
  task automatic push(input int inst, input logic [7:0] d, input bit align);
    $display("push inst=%0d data=0x%02h ready=%0b", inst, d, ready_v[inst]);
    tx_data = d;
    valid_v = 3'b000;
    valid_v[inst] = 1'b1;
    if (align) phase = tick_period - 1;
    cyc();
    valid_v = 3'b000;
  endtask

  task automatic capture(input int inst, input logic [7:0] d, input string tag, input int exp_gap,
                         input bit push_on_done, input logic [7:0] pd);
    logic exp_bits [12];
    int   nb, gap, cnt, dones, bit_clks, busy_at_done;
    bit_clks = OS * tick_period;
    nb = 0;
    exp_bits[nb] = 1'b0; nb++;
    for (int i = 0; i < 8; i++) begin
      exp_bits[nb] = d[i]; nb++;
    end
    if (par_en[inst] != 0) begin
      exp_bits[nb] = (^d) ^ (par_odd[inst] != 0); nb++;
    end
    for (int i = 0; i < stops[inst]; i++) begin
      exp_bits[nb] = 1'b1; nb++;
    end
    gap = 0;
    while (txd_v[inst] !== 1'b0 && gap < 5000) begin
      gap++;
      cyc();
    end
    chk({tag, "_start_seen"}, int'(txd_v[inst]), 0);
    if (exp_gap >= 0) chk({tag, "_gap"}, gap, exp_gap);
    dones = 0;
    busy_at_done = 0;
    for (int b = 0; b < nb; b++) begin
      cnt = 0;
      for (int s = 0; s < bit_clks; s++) begin
        if (txd_v[inst] === exp_bits[b]) cnt++;
        if (done_v[inst] === 1'b1) begin
          dones++;
          busy_at_done = int'(busy_v[inst]);
          if (push_on_done) begin
            tx_data = pd;
            valid_v[inst] = 1'b1;
          end
        end
        cyc();
        valid_v = 3'b000;
      end
      chk($sformatf("%s_bit%0d", tag, b), cnt, bit_clks);
    end
    chk({tag, "_txdone_pulses"}, dones, 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 1);
    $display("frame %s inst=%0d data=0x%02h bits=%0d gap=%0d", tag, inst, d, nb, gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", int'(txd_v[0]), 1);
    chk("rst_ready", int'(ready_v[0]), 1);
    chk("rst_busy", int'(busy_v[0]), 0);
    chk("rst_txdone", int'(done_v[0]), 0);
    chk("rst_txd_par", int'(txd_v[1]), 1);
    reset = 1'b1;
    cyc();

    // Defaults with a tick every 4 clks: 64 clks per bit.
    tick_period = 4;
    tick_en = 1'b1;
    push(0, 8'h55, 1);
    capture(0, 8'h55, "t1", -1, 0, 8'h00);
    chk("t1_busy_after", int'(busy_v[0]), 0);
    chk("t1_txd_idle", int'(txd_v[0]), 1);

    // Fill the FIFO with ticks stopped; the sixth byte must be refused.
    tick_en = 1'b0;
    for (int i = 1; i <= 5; i++) push(0, 8'(i), 0);
    chk("t2_ready_full", int'(ready_v[0]), 0);
    push(0, 8'h06, 0);
    chk("t2_ready_still_full", int'(ready_v[0]), 0);
    chk("t2_busy", int'(busy_v[0]), 1);
    tick_period = 1;
    phase = 0;
    tick_en = 1'b1;
    cyc();
    capture(0, 8'h01, "t2_f1", -1, 0, 8'h00);
    for (int i = 2; i <= 5; i++) capture(0, 8'(i), $sformatf("t2_f%0d", i), 0, 0, 8'h00);
    chk("t2_no_byte6_txd", int'(txd_v[0]), 1);
    chk("t2_no_byte6_busy", int'(busy_v[0]), 0);
    repeat (20) cyc();
    chk("t2_idle_txd", int'(txd_v[0]), 1);

    // Parity and two stop bits: 0x03 has even weight, so odd parity sends 1, even sends 0.
    push(1, 8'h03, 1);
    capture(1, 8'h03, "t3_odd", -1, 0, 8'h00);
    push(2, 8'h03, 1);
    capture(2, 8'h03, "t3_even", -1, 0, 8'h00);

    // Continuous ticks: 16 clks per bit, 160 clks per frame.
    push(0, 8'hA5, 1);
    capture(0, 8'hA5, "t4", -1, 0, 8'h00);

    // Push on the final-stop clk with an empty FIFO: one IDLE clk, then start.
    push(0, 8'h3C, 1);
    capture(0, 8'h3C, "t6a", -1, 1, 8'hC3);
    capture(0, 8'hC3, "t6b", 1, 0, 8'h00);
    // Second byte already queued: start follows the stop with no gap.
    push(0, 8'h81, 1);
    push(0, 8'h7E, 0);
    capture(0, 8'h81, "t6c", -1, 0, 8'h00);
    capture(0, 8'h7E, "t6d", 0, 0, 8'h00);

    // Abort mid data bit 3 of 0x00 with another byte queued.
    tick_period = 4;
    push(0, 8'h00, 1);
    push(0, 8'h77, 0);
    repeat (289) cyc();
    chk("t5_pre_rst_txd", int'(txd_v[0]), 0);
    chk("t5_pre_rst_busy", int'(busy_v[0]), 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_txd", int'(txd_v[0]), 1);
    chk("t5_rst_ready", int'(ready_v[0]), 1);
    chk("t5_rst_busy", int'(busy_v[0]), 0);
    chk("t5_rst_txdone", int'(done_v[0]), 0);
    @(negedge clk);
    repeat (3) cyc();
    reset = 1'b1;
    repeat (2) cyc();
    chk("t5_post_txd", int'(txd_v[0]), 1);
    chk("t5_post_busy", int'(busy_v[0]), 0);
    push(0, 8'h0F, 1);
    capture(0, 8'h0F, "t5_clean", -1, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the CPU_16bit_UART path. It is the send-side counterpart to the existing 16x-oversampling receiver.
- Accepts bytes from the CPU side through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Bit timing comes from the same 16x baud-tick enable the receiver uses, so both directions share one baud generator.

Parameters:
- OVERSAMPLE, 16: baud ticks per bit period; minimum 2.
- PARITY_EN, 0: 1 inserts a parity bit after D7.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- FIFO_DEPTH, 4: input buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- i_clk_tx  in  1  baud-tick enable; one clk wide, OVERSAMPLE ticks per bit.
- i_tx_data  in  8  byte to send.
- i_tx_valid  in  1  i_tx_data is valid.
- o_tx_ready  out  1  FIFO can accept a byte (FIFO not full).
- o_txd  out  1  serial line; idles high.
- o_tx_busy  out  1  frame in progress or FIFO non-empty.
- TxDone  out  1  one-clk pulse when a frame's final stop bit completes.

Behaviour:
- Reset (async, active-low) values: o_txd=1, o_tx_ready=1, o_tx_busy=0, TxDone=0. FIFO is emptied, FSM goes to IDLE, tick counter and bit counter are cleared.
- Write handshake: a byte is accepted on a clk edge where i_tx_valid && o_tx_ready. o_tx_ready is !full, registered. When full, writes are ignored and data is dropped; the source must hold valid.
- FIFO: synchronous, first-word-fall-through is not required. A byte written in cycle N becomes poppable in cycle N+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_txd=1. When the FIFO is non-empty, pop into an 8-bit shift register, clear the tick counter, go to START on the next clk. The pop does not wait for a tick.
- Bit timing: in every non-IDLE state the tick counter increments on each i_clk_tx. The bit ends on the tick where count==OVERSAMPLE-1; the counter then wraps to 0 and the FSM advances. Each bit therefore lasts exactly OVERSAMPLE ticks.
- START: o_txd=0, then go to DATA.
- DATA: o_txd = shift[0]. At each bit end, shift right and increment the bit counter. After bit 7, go to PARITY if PARITY_EN, else STOP.
- PARITY: o_txd = XOR of the 8 data bits, XOR PARITY_ODD. Then go to STOP.
- STOP: o_txd=1 for STOP_BITS bit periods. At the final bit end:
  - TxDone=1 for that single clk.
  - If the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle bit).
  - Otherwise go to IDLE.
- o_txd is registered, with no combinational path from any input. A state's value appears on the clk after the state is entered.
- o_tx_busy = (state != IDLE) || !fifo_empty.
- Simultaneous events:
  - Push and pop in the same clk: FIFO count is unchanged and both operations occur. This is legal even when full, because ready is computed from pre-edge state, so a full FIFO still rejects the push.
  - i_clk_tx high continuously: one tick per clk.
  - i_clk_tx and a state transition in the same clk: the tick is consumed by the bit that is ending.
- Reset asserted mid-frame: o_txd returns to 1 immediately (asynchronously), the partial frame is abandoned, and buffered bytes are lost.
- Unreachable state encodings recover to IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants for IDLE/START/DATA/PARITY/STOP;
  - defaults for OVERSAMPLE and data width (8);
  - the parity-calc function, reusable by the receiver.
- One sub-module: uart_tx_fifo (parameterised DEPTH and WIDTH; push/pop/full/empty/count; async active-low reset).
- FSM, tick counter, bit counter and shifter live in uart_tx.

Test Plan:
1. Defaults, tick every 4 clks; push 0x55 once → o_txd low for 64 clks, then 1,0,1,0,1,0,1,0 at 64 clks each, then high for 64 clks. TxDone pulses once at frame end; o_tx_busy drops on the next clk.
2. Hold i_clk_tx=0; push 0x01..0x06 on consecutive clks (FIFO_DEPTH=4) → 0x01 is popped into the shifter, 0x02..0x05 fill the FIFO, o_tx_ready falls, 0x06 is not accepted. Then enable ticks → frames 0x01..0x05 go out back-to-back with no idle gap, with 5 TxDone pulses.
3. PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2; push 0x03 → parity bit=1, followed by 2×OVERSAMPLE ticks of high stop. Repeat with PARITY_ODD=0 → parity bit=0.
4. i_clk_tx tied high; push 0xA5 → each bit lasts exactly 16 clks, full frame is 160 clks, LSB first (1,0,1,0,0,1,0,1).
5. Assert reset during DATA bit 3 → o_txd=1 immediately, o_tx_ready=1, o_tx_busy=0, no TxDone. After release, push 0x0F → a clean frame is sent.
6. Push in the same clk that STOP ends with the FIFO empty → frame starts after one IDLE clk. With the FIFO non-empty at STOP end, START follows with zero IDLE clks.
